// File: rtl/data_mem_bridge_pkg.sv
// Shared types and constants for the load/store bridge: FSM states, funct3 codes,
// access-size decoding and alignment rules.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT = 255;

    // funct3[1:0] encodes the size for loads and stores alike; funct3[2] is the unsigned flag.
    function automatic acc_size_t size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input acc_size_t sz, input logic [1:0] offset);
        case (sz)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~offset[0];
            default: return (offset == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// Valid/ready memory bus between the bridge (master) and the data memory or fabric (slave).
interface data_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_req_valid;
    logic                  bus_req_ready;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [31:0]           bus_wdata;
    logic                  bus_rsp_valid;
    logic [31:0]           bus_rsp_data;
    logic                  bus_rsp_err;

    modport master (
        output bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err
    );
endinterface

// File: rtl/data_mem_bridge_lsu_align.sv
// Combinational lane logic: store steering and byte enables from the core's request,
// load lane selection and sign/zero extension from the returned bus word.
module lsu_align (
    input  logic [2:0]  wr_funct,
    input  logic [1:0]  wr_offset,
    input  logic [31:0] wr_data,
    output logic        aligned,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_lanes,
    input  logic [2:0]  rd_funct,
    input  logic [1:0]  rd_offset,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_ext
);
    import lsu_pkg::*;

    acc_size_t   wr_size;
    acc_size_t   rd_size;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        wr_size  = size_of(wr_funct);
        aligned  = is_aligned(wr_size, wr_offset);
        wr_be    = 4'b1111;
        wr_lanes = wr_data;
        case (wr_size)
            SZ_BYTE: begin
                wr_be    = 4'b0001 << wr_offset;
                wr_lanes = {4{wr_data[7:0]}};
            end
            SZ_HALF: begin
                wr_be    = 4'b0011 << wr_offset;
                wr_lanes = {2{wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_size = size_of(rd_funct);
        rd_byte = rd_word[{rd_offset, 3'b000} +: 8];
        rd_half = rd_offset[1] ? rd_word[31:16] : rd_word[15:0];
        rd_ext  = rd_word;
        case (rd_size)
            SZ_BYTE: rd_ext = rd_funct[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_ext = rd_funct[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Load/store bridge: turns the core's held MemRead/MemWrite strobes into one registered
// valid/ready bus transaction, stalling the core until the access completes or times out.
module data_mem_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = lsu_pkg::DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0] m_wr_dat,
    output logic [DATA_WIDTH-1:0] m_rd_dat,
    output logic                  stall,
    output logic                  misalign,
    output logic                  bus_err,
    data_mem_bridge_if.master     bus
);
    import lsu_pkg::*;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [2:0]       funct_q;
    logic [1:0]       offset_q;

    logic             access;
    logic             aligned;
    logic             start;
    logic             timed_out;
    logic [3:0]       be_new;
    logic [31:0]      wdata_new;
    logic [31:0]      rd_ext;

    lsu_align u_align (
        .wr_funct  (funct),
        .wr_offset (m_addr[1:0]),
        .wr_data   (m_wr_dat),
        .aligned   (aligned),
        .wr_be     (be_new),
        .wr_lanes  (wdata_new),
        .rd_funct  (funct_q),
        .rd_offset (offset_q),
        .rd_word   (bus.bus_rsp_data),
        .rd_ext    (rd_ext)
    );

    // Core-facing handshake is combinational so the stall starts in the detecting cycle;
    // gating with reset keeps it quiet while reset is asserted.
    assign access    = MemRead | MemWrite;
    assign start     = reset & (state == S_IDLE) & access & aligned;
    assign misalign  = reset & (state == S_IDLE) & access & ~aligned;
    assign stall     = start | (state == S_REQ) | (state == S_WAIT);
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (timed_out)              state_nxt = S_DONE;
                else if (bus.bus_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.bus_rsp_valid || timed_out) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            cnt               <= '0;
            we_q              <= 1'b0;
            funct_q           <= 3'b000;
            offset_q          <= 2'b00;
            m_rd_dat          <= '0;
            bus_err           <= 1'b0;
            bus.bus_req_valid <= 1'b0;
            bus.bus_we        <= 1'b0;
            bus.bus_addr      <= '0;
            bus.bus_be        <= 4'b0000;
            bus.bus_wdata     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        we_q              <= MemWrite;
                        funct_q           <= funct;
                        offset_q          <= m_addr[1:0];
                        cnt               <= '0;
                        bus_err           <= 1'b0;
                        bus.bus_req_valid <= 1'b1;
                        bus.bus_we        <= MemWrite;
                        bus.bus_addr      <= {m_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus.bus_be        <= be_new;
                        bus.bus_wdata     <= wdata_new;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (timed_out) begin
                        bus.bus_req_valid <= 1'b0;
                        bus_err           <= 1'b1;
                    end else if (bus.bus_req_ready) begin
                        bus.bus_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A response arriving on the last allowed cycle still wins over the timeout.
                    if (bus.bus_rsp_valid) begin
                        if (!we_q) m_rd_dat <= rd_ext;
                        bus_err <= bus.bus_rsp_err;
                    end else if (timed_out) begin
                        bus_err <= 1'b1;
                    end
                end
                default: bus_err <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: directed cases plus randomized loads/stores
// compared against an arithmetic model of byte enables, lane replication and extension.
module tb_data_mem_bridge;
    import lsu_pkg::*;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct;
    logic [31:0] m_addr, m_wr_dat, m_rd_dat;
    logic        stall, misalign, bus_err;

    data_mem_bridge_if #(.ADDR_WIDTH(32)) bus_if ();

    data_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .funct    (funct),
        .m_addr   (m_addr),
        .m_wr_dat (m_wr_dat),
        .m_rd_dat (m_rd_dat),
        .stall    (stall),
        .misalign (misalign),
        .bus_err  (bus_err),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd   = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: sizes in bytes, masks and multiplications instead of bit slicing.
    function automatic int unsigned nbytes(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_aligned(input logic [2:0] f, input logic [31:0] a);
        return (a % nbytes(f)) == 0;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f, input logic [31:0] a);
        return ((32'd1 << nbytes(f)) - 32'd1) << (a % 4);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
        case (nbytes(f))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] word);
        int unsigned n;
        longint      v;
        n = nbytes(f);
        if (n == 4) return word;
        v = longint'((word >> (8 * (a % 4)))) & ((64'd1 << (8 * n)) - 1);
        if (!f[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return 32'(v);
    endfunction

    // Starts right after a rising edge with the DUT in IDLE; returns likewise.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input int ready_dly, input int rsp_dly,
                          input logic [31:0] rsp_word, input bit rsp_err, input string tag);
        bit ok;
        bit in_req;
        bit done;
        bit tmo;
        int k;
        int left;
        int stalls;
        ok     = model_aligned(f, a);
        in_req = 1'b1;
        done   = 1'b0;
        tmo    = 1'b0;
        k      = 0;
        stalls = 1;
        MemRead  = rd;
        MemWrite = wr;
        funct    = f;
        m_addr   = a;
        m_wr_dat = d;
        @(negedge clk);
        check({tag, ":misalign"}, misalign, !ok);
        check({tag, ":stall_c0"}, stall, ok);
        if (!ok) begin
            check({tag, ":no_valid_c0"}, bus_if.bus_req_valid, 0);
            @(posedge clk); #1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            @(negedge clk);
            check({tag, ":no_valid"}, bus_if.bus_req_valid, 0);
            check({tag, ":misalign_off"}, misalign, 0);
            check({tag, ":rd_hold"}, m_rd_dat, exp_rd);
            @(posedge clk); #1;
            return;
        end
        left = ready_dly;
        while (!done) begin
            @(posedge clk); #1;
            bus_if.bus_req_ready = in_req && (left == 0);
            // Stray responses during the request phase must be ignored.
            bus_if.bus_rsp_valid = in_req ? 1'($urandom_range(0, 1)) : (left == 0);
            bus_if.bus_rsp_data  = in_req ? ~rsp_word : rsp_word;
            bus_if.bus_rsp_err   = in_req ? 1'b1 : rsp_err;
            @(negedge clk);
            if (k == 0) begin
                check({tag, ":addr"},  bus_if.bus_addr,  a & ~32'h3);
                check({tag, ":be"},    bus_if.bus_be,    model_be(f, a));
                check({tag, ":wdata"}, bus_if.bus_wdata, wr ? model_wdata(f, d) : bus_if.bus_wdata);
                check({tag, ":we"},    bus_if.bus_we,    wr);
            end
            check({tag, ":valid"}, bus_if.bus_req_valid, in_req);
            if (stall) stalls++;
            k++;
            if (in_req) begin
                if (k == TO) begin tmo = 1'b1; done = 1'b1; end
                else if (left == 0) begin in_req = 1'b0; left = rsp_dly; end
                else left--;
            end else begin
                if (left == 0) done = 1'b1;
                else if (k == TO) begin tmo = 1'b1; done = 1'b1; end
                else left--;
            end
        end
        @(posedge clk); #1;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_err   = 1'b0;
        @(negedge clk);
        if (!tmo && !wr) exp_rd = model_load(f, a, rsp_word);
        check({tag, ":done_stall"}, stall, 0);
        check({tag, ":done_err"},   bus_err, tmo | rsp_err);
        check({tag, ":done_valid"}, bus_if.bus_req_valid, 0);
        check({tag, ":rd_dat"},     m_rd_dat, exp_rd);
        check({tag, ":stall_cycles"}, stalls, k + 1);
        @(posedge clk); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ld_f [5];
        logic [2:0]  st_f [3];
        int          sel;
        bit          rd, wr;
        logic [2:0]  f;
        ld_f = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        st_f = '{F3_B, F3_H, F3_W};

        reset    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct    = 3'b000;
        m_addr   = 32'h0;
        m_wr_dat = 32'h0;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_data  = 32'h0;
        bus_if.bus_rsp_err   = 1'b0;
        #3;
        check("rst:m_rd_dat", m_rd_dat, 0);
        check("rst:stall",    stall, 0);
        check("rst:misalign", misalign, 0);
        check("rst:bus_err",  bus_err, 0);
        check("rst:valid",    bus_if.bus_req_valid, 0);
        check("rst:we",       bus_if.bus_we, 0);
        check("rst:addr",     bus_if.bus_addr, 0);
        check("rst:be",       bus_if.bus_be, 0);
        check("rst:wdata",    bus_if.bus_wdata, 0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        run_op(1, 0, F3_W,  32'h100, 32'h0,  0, 0, 32'hDEADBEEF, 0, "lw_min");
        check("lw_min:const", m_rd_dat, 32'hDEADBEEF);
        run_op(0, 1, F3_B,  32'h203, 32'hA5, 0, 0, 32'h0, 0, "sb");
        run_op(1, 0, F3_B,  32'h2,   32'h0,  0, 0, 32'h00800000, 0, "lb");
        check("lb:const", m_rd_dat, 32'hFFFFFF80);
        run_op(1, 0, F3_BU, 32'h2,   32'h0,  1, 2, 32'h00800000, 0, "lbu");
        check("lbu:const", m_rd_dat, 32'h00000080);
        run_op(1, 0, F3_HU, 32'h2,   32'h0,  0, 0, 32'h00800000, 0, "lhu");
        check("lhu:const", m_rd_dat, 32'h00000080);
        run_op(1, 0, F3_H,  32'h101, 32'h0,  0, 0, 32'h0, 0, "lh_mis");
        run_op(0, 1, F3_W,  32'h102, 32'h0,  0, 0, 32'h0, 0, "sw_mis");
        run_op(1, 1, F3_H,  32'h22,  32'h1234BEEF, 2, 1, 32'h55555555, 0, "both_sh");
        run_op(1, 0, F3_H,  32'h6,   32'h0,  0, 3, 32'h8001CAFE, 1, "lh_err");
        run_op(1, 0, F3_W,  32'h300, 32'h0,  300, 0, 32'h0, 0, "timeout");

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            wr  = (sel < 4);
            rd  = !wr || (sel == 0);
            f   = wr ? st_f[$urandom_range(0, 2)] : ld_f[$urandom_range(0, 4)];
            run_op(rd, wr, f, $urandom(), $urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom(), ($urandom_range(0, 7) == 0), "rand");
        end

        // Asynchronous reset in the middle of a read, then a late response that must be ignored.
        run_op(1, 0, F3_W, 32'h400, 32'h0, 0, 0, 32'h13579BDF, 0, "pre_rst");
        MemRead = 1'b1;
        funct   = F3_W;
        m_addr  = 32'h404;
        @(posedge clk); #1;
        bus_if.bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_req_ready = 1'b0;
        @(negedge clk);
        check("mid:stall_wait", stall, 1);
        #2 reset = 1'b0;
        #1;
        MemRead = 1'b0;
        exp_rd  = 32'h0;
        check("mid_rst:m_rd_dat", m_rd_dat, exp_rd);
        check("mid_rst:stall",    stall, 0);
        check("mid_rst:valid",    bus_if.bus_req_valid, 0);
        check("mid_rst:addr",     bus_if.bus_addr, 0);
        check("mid_rst:be",       bus_if.bus_be, 0);
        check("mid_rst:wdata",    bus_if.bus_wdata, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rsp_data  = 32'hCAFEF00D;
        bus_if.bus_rsp_err   = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_err   = 1'b0;
        @(negedge clk);
        check("post_rst:m_rd_dat", m_rd_dat, 0);
        check("post_rst:stall",    stall, 0);
        check("post_rst:bus_err",  bus_err, 0);
        check("post_rst:valid",    bus_if.bus_req_valid, 0);
        @(posedge clk); #1;
        run_op(1, 0, F3_B, 32'h501, 32'h0, 0, 0, 32'h0000F700, 0, "post_rst_lb");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
